// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store memory responder with wait states and access-error reporting
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [63:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    input  logic [63:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [63:0] RSP_RDATA,
    output logic        RSP_ERR
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [63:0]   BYTES    = 64'(DEPTH) * 64'd8;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept, execute;

    logic          we_q;
    logic [63:0]   addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [63:0]   wdata_q;

    logic [63:0]   mem [DEPTH];

    logic [3:0]    nbytes;
    logic          misaligned, out_of_range, err;
    logic [IW-1:0] idx;
    logic [5:0]    bit_off;
    logic [7:0]    mask, be;
    logic [63:0]   wshift, word, lane, ld_data;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        execute   = 1'b0;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    execute   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready depends only on registered state and RESET, never on RSP_READY.
    assign REQ_READY = (state == IDLE) && !RESET;
    assign RSP_VALID = (state == RESP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (execute) begin
                RSP_ERR   <= err;
                RSP_RDATA <= (err || we_q) ? 64'd0 : ld_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && accept) begin
            we_q    <= REQ_WE;
            addr_q  <= REQ_ADDR;
            size_q  <= REQ_SIZE;
            uns_q   <= REQ_UNSIGNED;
            wdata_q <= REQ_WDATA;
        end
    end

    always_comb begin
        nbytes = 4'd1 << size_q;
        case (size_q)
            2'd0:    begin misaligned = 1'b0;          mask = 8'h01; end
            2'd1:    begin misaligned = addr_q[0];     mask = 8'h03; end
            2'd2:    begin misaligned = |addr_q[1:0];  mask = 8'h0F; end
            default: begin misaligned = |addr_q[2:0];  mask = 8'hFF; end
        endcase
        out_of_range = addr_q > (BYTES - {60'd0, nbytes});
        err          = misaligned || out_of_range;
        idx          = addr_q[IW+2:3];
        bit_off      = {addr_q[2:0], 3'b000};
        be           = mask << addr_q[2:0];
        wshift       = wdata_q << bit_off;
        word         = mem[idx];
        lane         = word >> bit_off;
    end

    // Sign fill is suppressed for unsigned loads; doublewords need no fill.
    always_comb begin
        case (size_q)
            2'd0:    ld_data = {{56{~uns_q & lane[7]}},  lane[7:0]};
            2'd1:    ld_data = {{48{~uns_q & lane[15]}}, lane[15:0]};
            2'd2:    ld_data = {{32{~uns_q & lane[31]}}, lane[31:0]};
            default: ld_data = lane;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET && execute && we_q && !err) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multicycle RISC-V datapath: the memory end of the processor's load/store port. It accepts one request at a time over a valid/ready handshake and models a configurable number of wait states. It performs byte/half/word/doubleword accesses on a little-endian 64-bit word array and returns sign- or zero-extended load data. Misaligned and out-of-range accesses are reported through an error flag, not executed.

## Interface
- DEPTH, default 256: number of 64-bit words; byte address range is 0 .. DEPTH*8-1.
- LATENCY, default 2: wait cycles between acceptance and the response; 0 is legal.
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  responder can accept a request.
- REQ_WE  input  1  1 = store, 0 = load.
- REQ_ADDR  input  64  byte address.
- REQ_SIZE  input  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- REQ_UNSIGNED  input  1  loads only: 1 = zero-extend (lbu/lhu/lwu), 0 = sign-extend.
- REQ_WDATA  input  64  store data, right-justified (bits [8*2^SIZE-1:0] are used).
- RSP_VALID  output  1  response present.
- RSP_READY  input  1  requester takes the response.
- RSP_RDATA  output  64  load data, extended to 64 bits. 0 for stores and errors.
- RSP_ERR  output  1  request was misaligned or out of range.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - REQ_READY=1.
  - On REQ_VALID, capture WE, ADDR, SIZE, UNSIGNED and WDATA into internal registers.
  - Load the cycle counter with LATENCY and go to WAIT.
- **WAIT**
  - REQ_READY=0.
  - While the counter is not 0, decrement it.
  - When the counter is 0, execute the access and go to RESP at the same edge.
  - With LATENCY=0, WAIT lasts exactly one cycle.
- **Access execution** (at the WAIT→RESP edge)
  - Word index = ADDR[63:3]; lane offset = ADDR[2:0].
  - Error if ADDR mod 2^SIZE ≠ 0, or if ADDR > DEPTH*8 - 2^SIZE.
  - On error: no array write, RSP_RDATA=0, RSP_ERR=1.
  - Store: write only bytes offset .. offset+2^SIZE-1 from WDATA's low bytes. Other bytes of the word are unchanged.
  - Load: take 2^SIZE bytes starting at the offset. Sign-extend from the top extracted bit unless UNSIGNED is set. A doubleword load ignores UNSIGNED.
- **RESP**
  - RSP_VALID=1, and RSP_RDATA/RSP_ERR are held stable.
  - When RSP_READY is seen, go to IDLE.
- The request inputs are ignored outside IDLE, and captured values are never re-sampled.
- Array contents are not cleared by RESET.

## Timing
- **Reset values:**
  - State=IDLE.
  - REQ_READY=0 while RESET is high, then 1 from the first cycle after RESET is released.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, counter=0.
- **Acceptance:** a request is accepted at the edge where REQ_VALID=1 and REQ_READY=1.
- **Response:** if acceptance is at edge k, RSP_VALID rises after edge k+1+LATENCY.
- **Store commit:** store data is committed at that same edge, k+1+LATENCY.
- **Release and back-to-back requests:**
  - The response is released at the first edge where RSP_VALID=1 and RSP_READY=1.
  - REQ_READY is 1 in the following cycle.
  - Minimum request-to-request spacing is LATENCY+3 cycles.
- **RSP_READY held high:** the response still lasts exactly one cycle, and there is no combinational path from RSP_READY to REQ_READY.
- **Reset mid-operation:**
  - RESET during WAIT aborts the access; a pending store is never written.
  - RESET during RESP drops RSP_VALID. The already-committed store remains.
- **RESET and REQ_VALID together:** RESET wins and the request is not accepted.
- **Backpressure:** RSP_READY low holds RESP indefinitely, with outputs stable.

## Test plan
- Store then load, doubleword:
  - Stimulus: store SIZE=3 at addr 0x10 with 0x1122334455667788, then load SIZE=3 at 0x10.
  - Required: RSP_RDATA=0x1122334455667788 and RSP_ERR=0.
  - Required: RSP_VALID rises exactly LATENCY+1 cycles after acceptance.
- Byte lanes and extension:
  - Stimulus: store byte 0x80 at 0x13, then load byte signed at 0x13, then load byte unsigned at 0x13, then load doubleword at 0x10.
  - Required: 0xFFFFFFFFFFFFFF80, then 0x80, then 0x1122334480667788.
- Half/word extension:
  - Stimulus: store word 0x8000F00D at 0x20, then load word signed, then load word unsigned, then load half signed at 0x20.
  - Required: 0xFFFFFFFF8000F00D, then 0x000000008000F00D, then 0xFFFFFFFFFFFFF00D.
- Errors:
  - Stimulus: store half at 0x21, then load word at DEPTH*8-2.
  - Required: RSP_ERR=1 and RSP_RDATA=0 for both.
  - Required: a follow-up load at 0x20 still returns 0x8000F00D (no corruption).
- Backpressure and reset:
  - Stimulus: hold RSP_READY=0 for 5 cycles.
  - Required: RSP_VALID and RSP_RDATA stay stable and REQ_READY=0.
  - Stimulus: assert RESET in WAIT of a store of 0xDEAD to 0x40.
  - Required: a later load at 0x40 returns the old value.
  - Required: REQ_READY=1 in the first cycle after reset is released.
